sonar_tof_capture: RTL
======================

# sonar_tof_capture

Time-of-flight capture stage downstream of the SonarOnChip comparator. Timestamps each rising edge of the comparator output (`cmp`), counted in `ce_pcm` ticks since the last ping start, and buffers the stamps in a small FIFO. The management SoC reads the FIFO over the same 16-bit slave port used by SonarOnChip, behind the top-level address decoder. The block raises an interrupt when data is pending or a stamp was lost.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, 2..16.
- `TS_WIDTH`, 16: timestamp width; must be ≤ 16.
- `HOLDOFF_RST`, 4: reset value of the holdoff register, in `ce_pcm` ticks.

- `wb_clk_i`  in  1  sole clock.
- `wb_rst_n_i`  in  1  reset; asynchronous assert, active-low.
- `wb_valid_i`  in  1  slave select from the top-level decoder; held until `wbs_ack_o`.
- `wbs_adr_i`  in  4  register index.
- `wbs_dat_i`  in  16  write data.
- `wbs_strb_i`  in  1  1 = write, 0 = read.
- `wbs_ack_o`  out  1  single-cycle acknowledge.
- `wbs_dat_o`  out  16  read data; valid while `wbs_ack_o` is high.
- `ce_pcm`  in  1  timebase clock enable, one cycle wide.
- `cmp_i`  in  1  comparator output from SonarOnChip; synchronous to `wb_clk_i`.
- `ping_i`  in  1  ping start; level input, rising-edge detected.
- `irq_o`  out  1  interrupt, level.

## Operation
- **Registers:**
  - 0 CTRL (RW):
    - bit0 `en`.
    - bit1 `flush`: write 1 empties the FIFO; self-clearing; reads back 0.
    - bit2 `irq_en`.
  - 1 STATUS (R, plus W1C on bit6):
    - [4:0] `count`.
    - bit5 `empty`.
    - bit6 `ovf`: sticky.
    - bit7 `full`.
    - [9:8] `state`.
  - 2 DATA (R): returns the FIFO head and pops it. When empty, returns 0x0000 and does not pop. Writes are ignored.
  - 3 HOLDOFF (RW): [7:0] holdoff length in `ce_pcm` ticks.
  - Other addresses: read 0x0000, writes ignored, ack still issued.
- **Edge detect:** `cmp_i` and `ping_i` are each registered once; an edge is `cur & ~prev`.
- **State machine** (2-bit encoding, shared package):
  - IDLE (0): timestamp counter held at 0.
    - Ping edge with `en` = 1 → clear counter, go to ARMED.
  - ARMED (1): counter increments on each `ce_pcm`.
    - `cmp_i` edge → push counter value, go to HOLD, load the holdoff counter.
    - Counter reaches all-ones → IDLE (timeout); no push.
  - HOLD (2): counter keeps running; holdoff counter decrements on `ce_pcm`.
    - Holdoff reaches 0 → ARMED.
    - Holdoff value 0 → return to ARMED on the next cycle.
    - Counter saturates → IDLE.
  - From any state:
    - Ping edge with `en` = 1 → counter cleared, go to ARMED. Takes priority over a `cmp_i` edge in the same cycle; no push occurs.
    - `en` written to 0 → IDLE next cycle. FIFO contents are kept.
- **FIFO:**
  - Push while full: stamp dropped, `ovf` set.
  - Push and pop in the same cycle: both take effect, `count` unchanged. This holds when full: the push is accepted.
  - `flush` together with a push: flush wins, FIFO ends empty.
- **Width:** stamps are zero-extended to 16 bits on DATA.
- **Interrupt:** `irq_o = (irq_en & ~empty) | ovf`. Registered.

## Timing
- **Bus handshake:**
  - `wbs_ack_o` rises the cycle after `wb_valid_i` first goes high and lasts exactly one cycle.
  - No new ack is issued until `wb_valid_i` has been low for at least one cycle.
  - The write side effect and the DATA pop happen on the ack cycle.
- **Push latency:** the stamp is in the FIFO 2 cycles after `cmp_i` rises (sync register, then edge/push). `count`, `empty` and `irq_o` update one cycle after that.
- **Stamp value:** a stamp equals the number of `ce_pcm` pulses seen since the ping edge was registered.
- **Reset values:**
  - Outputs: `wbs_ack_o` = 0, `wbs_dat_o` = 0, `irq_o` = 0.
  - Internal: state IDLE, FIFO empty, `ovf` = 0, CTRL = 0, HOLDOFF = `HOLDOFF_RST`.
- **Reset mid-transaction:** asserting reset during a transaction aborts it; no ack follows.

## Structure
- Package `sonar_tof_pkg` holds:
  - register indices;
  - the state enum;
  - STATUS bit positions.
- Sub-module `tof_fifo`: synchronous FIFO with parameters `DEPTH` and `WIDTH`, `push`/`pop`/`flush` inputs, and `count`/`full`/`empty` outputs.
- The top holds:
  - edge detect;
  - the FSM;
  - the timestamp and holdoff counters;
  - the register file.

## Test plan
- **Single echo:** `en` = 1, ping, 37 `ce_pcm` pulses, `cmp_i` edge → STATUS `count` = 1. DATA read returns 0x0025, then STATUS `empty` = 1.
- **Holdoff:** HOLDOFF = 4; `cmp_i` edges at ticks 10, 12 and 15 → only 10 and 15 are stored.
- **Overflow:** 9 echoes with `DEPTH` = 8 → `count` = 8, `full` = 1, `ovf` = 1, `irq_o` = 1. Writing STATUS bit6 = 1 clears `ovf`; FIFO still holds 8 entries.
- **Timeout:** ping followed by 65535 ticks with no echo → state IDLE, FIFO empty. A `cmp_i` edge afterwards is ignored.
- **Read while full during push:** DATA read acked in the same cycle as a push into a full FIFO → `count` stays 8, no `ovf`.
- **Reset and empty read:** async reset asserted mid-HOLD → outputs 0 immediately. DATA read when empty returns 0x0000 with one ack.

Source files
------------

// File: rtl/sonar_tof_capture_pkg.sv
// Shared definitions for the sonar time-of-flight capture block:
// register map, capture FSM states and STATUS field layout.
package sonar_tof_pkg;

  localparam logic [3:0] REG_CTRL    = 4'd0;
  localparam logic [3:0] REG_STATUS  = 4'd1;
  localparam logic [3:0] REG_DATA    = 4'd2;
  localparam logic [3:0] REG_HOLDOFF = 4'd3;

  localparam int CTRL_EN_BIT     = 0;
  localparam int CTRL_FLUSH_BIT  = 1;
  localparam int CTRL_IRQ_EN_BIT = 2;

  localparam int STAT_COUNT_LSB = 0;
  localparam int STAT_EMPTY_BIT = 5;
  localparam int STAT_OVF_BIT   = 6;
  localparam int STAT_FULL_BIT  = 7;
  localparam int STAT_STATE_LSB = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_HOLD  = 2'd2
  } tof_state_e;

  function automatic logic [15:0] pack_status(
    input logic [4:0] count,
    input logic       empty,
    input logic       ovf,
    input logic       full,
    input tof_state_e state
  );
    logic [15:0] s;
    s = '0;
    s[STAT_COUNT_LSB +: 5] = count;
    s[STAT_EMPTY_BIT]      = empty;
    s[STAT_OVF_BIT]        = ovf;
    s[STAT_FULL_BIT]       = full;
    s[STAT_STATE_LSB +: 2] = state;
    return s;
  endfunction

endpackage

// File: rtl/sonar_tof_capture_if.sv
// 16-bit management slave port shared with SonarOnChip; the decoder-side
// master drives select/address/data, the capture block answers with ack/data.
interface sonar_tof_capture_if;
  logic        wb_valid_i;
  logic [3:0]  wbs_adr_i;
  logic [15:0] wbs_dat_i;
  logic        wbs_strb_i;
  logic        wbs_ack_o;
  logic [15:0] wbs_dat_o;

  modport master (
    output wb_valid_i, wbs_adr_i, wbs_dat_i, wbs_strb_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wb_valid_i, wbs_adr_i, wbs_dat_i, wbs_strb_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/sonar_tof_capture_fifo.sv
// Small synchronous FIFO for timestamps. A push into a full FIFO is accepted
// when a pop happens in the same cycle; otherwise it is dropped and flagged.
module tof_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_flush,
  input  logic [WIDTH-1:0]         i_wr_data,
  output logic [WIDTH-1:0]         o_rd_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty,
  output logic                     o_drop
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_count   = r_count;
  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_rd_data = r_mem[r_rd_ptr];

  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);
  // A stamp discarded by a simultaneous flush is not an overflow.
  assign o_drop    = i_push & ~w_do_push & ~i_flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wr_data;
  end

endmodule

// File: rtl/sonar_tof_capture.sv
// Echo time-of-flight capture: timestamps comparator rising edges relative to
// the last ping, buffers them in a FIFO and exposes them on the slave port.
module sonar_tof_capture
  import sonar_tof_pkg::*;
#(
  parameter int          DEPTH       = 8,
  parameter int          TS_WIDTH    = 16,   // at most 16
  parameter logic [7:0]  HOLDOFF_RST = 8'd4
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_n_i,
  sonar_tof_capture_if.slave   bus,
  input  logic                 ce_pcm,
  input  logic                 cmp_i,
  input  logic                 ping_i,
  output logic                 irq_o
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic                r_cmp_s, r_cmp_p;
  logic                r_ping_s, r_ping_p;
  logic                w_cmp_edge, w_ping_edge;

  tof_state_e          r_state;
  logic [TS_WIDTH-1:0] r_ts;
  logic [7:0]          r_hold;
  logic                w_ts_max;
  logic                w_push;

  logic                r_en, r_irq_en, r_ovf, r_irq;
  logic [7:0]          r_holdoff;
  logic                r_ack, r_done;
  logic [15:0]         r_dat;

  logic                w_req, w_wr, w_rd;
  logic                w_pop, w_flush, w_ovf_clr;
  logic [15:0]         w_rd_mux;

  logic [TS_WIDTH-1:0] w_fifo_head;
  logic [CW-1:0]       w_fifo_count;
  logic                w_fifo_full, w_fifo_empty, w_fifo_drop;
  logic                w_unused_dat;

  assign w_unused_dat = ^bus.wbs_dat_i[15:8];

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_cmp_s  <= 1'b0;
      r_cmp_p  <= 1'b0;
      r_ping_s <= 1'b0;
      r_ping_p <= 1'b0;
    end else begin
      r_cmp_s  <= cmp_i;
      r_cmp_p  <= r_cmp_s;
      r_ping_s <= ping_i;
      r_ping_p <= r_ping_s;
    end
  end

  assign w_cmp_edge  = r_cmp_s & ~r_cmp_p;
  assign w_ping_edge = r_ping_s & ~r_ping_p;
  assign w_ts_max    = &r_ts;

  // A ping edge in the same cycle as an echo restarts the measurement instead.
  assign w_push = r_en & ~w_ping_edge & (r_state == ST_ARMED) & w_cmp_edge & ~w_ts_max;

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_state <= ST_IDLE;
      r_ts    <= '0;
      r_hold  <= '0;
    end else if (!r_en) begin
      r_state <= ST_IDLE;
      r_ts    <= '0;
    end else if (w_ping_edge) begin
      r_state <= ST_ARMED;
      r_ts    <= '0;
    end else begin
      case (r_state)
        ST_ARMED: begin
          if (w_ts_max) begin
            r_state <= ST_IDLE;
            r_ts    <= '0;
          end else begin
            if (ce_pcm) r_ts <= r_ts + 1'b1;
            if (w_cmp_edge) begin
              r_state <= ST_HOLD;
              r_hold  <= r_holdoff;
            end
          end
        end
        ST_HOLD: begin
          if (w_ts_max) begin
            r_state <= ST_IDLE;
            r_ts    <= '0;
          end else begin
            if (ce_pcm) r_ts <= r_ts + 1'b1;
            if (r_hold == '0)  r_state <= ST_ARMED;
            else if (ce_pcm)   r_hold  <= r_hold - 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_ts    <= '0;
        end
      endcase
    end
  end

  tof_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (TS_WIDTH)
  ) u_fifo (
    .clk       (wb_clk_i),
    .rst_n     (wb_rst_n_i),
    .i_push    (w_push),
    .i_pop     (w_pop),
    .i_flush   (w_flush),
    .i_wr_data (r_ts),
    .o_rd_data (w_fifo_head),
    .o_count   (w_fifo_count),
    .o_full    (w_fifo_full),
    .o_empty   (w_fifo_empty),
    .o_drop    (w_fifo_drop)
  );

  // One request per select assertion; r_done blocks re-acks until select drops.
  assign w_req     = bus.wb_valid_i & ~r_done;
  assign w_wr      = w_req & bus.wbs_strb_i;
  assign w_rd      = w_req & ~bus.wbs_strb_i;
  assign w_pop     = w_rd & (bus.wbs_adr_i == REG_DATA) & ~w_fifo_empty;
  assign w_flush   = w_wr & (bus.wbs_adr_i == REG_CTRL) & bus.wbs_dat_i[CTRL_FLUSH_BIT];
  assign w_ovf_clr = w_wr & (bus.wbs_adr_i == REG_STATUS) & bus.wbs_dat_i[STAT_OVF_BIT];

  always_comb begin
    w_rd_mux = '0;
    case (bus.wbs_adr_i)
      REG_CTRL: begin
        w_rd_mux[CTRL_EN_BIT]     = r_en;
        w_rd_mux[CTRL_IRQ_EN_BIT] = r_irq_en;
      end
      REG_STATUS:  w_rd_mux = pack_status(5'(w_fifo_count), w_fifo_empty, r_ovf,
                                          w_fifo_full, r_state);
      REG_DATA:    w_rd_mux = w_fifo_empty ? 16'h0000 : 16'(w_fifo_head);
      REG_HOLDOFF: w_rd_mux[7:0] = r_holdoff;
      default:     w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_ack  <= 1'b0;
      r_done <= 1'b0;
      r_dat  <= '0;
    end else begin
      r_ack <= w_req;
      r_dat <= w_rd ? w_rd_mux : 16'h0000;
      if (w_req)                 r_done <= 1'b1;
      else if (!bus.wb_valid_i)  r_done <= 1'b0;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_en      <= 1'b0;
      r_irq_en  <= 1'b0;
      r_holdoff <= HOLDOFF_RST;
      r_ovf     <= 1'b0;
      r_irq     <= 1'b0;
    end else begin
      if (w_wr && bus.wbs_adr_i == REG_CTRL) begin
        r_en     <= bus.wbs_dat_i[CTRL_EN_BIT];
        r_irq_en <= bus.wbs_dat_i[CTRL_IRQ_EN_BIT];
      end
      if (w_wr && bus.wbs_adr_i == REG_HOLDOFF) r_holdoff <= bus.wbs_dat_i[7:0];
      if (w_fifo_drop)    r_ovf <= 1'b1;
      else if (w_ovf_clr) r_ovf <= 1'b0;
      r_irq <= (r_irq_en & ~w_fifo_empty) | r_ovf;
    end
  end

  assign bus.wbs_ack_o = r_ack;
  assign bus.wbs_dat_o = r_dat;
  assign irq_o         = r_irq;

endmodule
